// File: rtl/board_renderer_pkg.sv
// Shared constants, state encodings and helpers for the tile-map renderer
// and the game controller that drives it.
package board_renderer_pkg;

  localparam int unsigned COLS        = 20;
  localparam int unsigned ROWS        = 15;
  localparam int unsigned TILE_SHIFT  = 3;
  localparam int unsigned GO_CYCLES   = 2;
  localparam int unsigned DRAW_CYCLES = 72;

  localparam int unsigned COL_W  = 5;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned CNT_W  = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_RD_WAIT   = 3'd2,
    ST_GO        = 3'd3,
    ST_DRAW_WAIT = 3'd4,
    ST_ADVANCE   = 3'd5
  } state_e;

  typedef enum logic {
    MODE_FULL   = 1'b0,
    MODE_SINGLE = 1'b1
  } mode_e;

  // row*20 + col as a shift-add; only used for single-tile requests.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [COL_W-1:0] col,
                                                  input logic [ROW_W-1:0] row);
    return (ADDR_W'(row) << 4) + (ADDR_W'(row) << 2) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Request, map-RAM and drawer signals between the game controller and the renderer.
interface board_renderer_if;
  import board_renderer_pkg::*;

  logic              start;
  logic              tile_req;
  logic [COL_W-1:0]  tile_col;
  logic [ROW_W-1:0]  tile_row;
  logic [ADDR_W-1:0] map_addr;
  logic [ID_W-1:0]   map_data;
  logic [X_W-1:0]    x_out;
  logic [Y_W-1:0]    y_out;
  logic [ID_W-1:0]   sprite_id_out;
  logic              begin_draw;
  logic              busy;
  logic              done;
  logic              req_err;

  modport master (
    output start, tile_req, tile_col, tile_row, map_data,
    input  map_addr, x_out, y_out, sprite_id_out, begin_draw, busy, done, req_err
  );

  modport slave (
    input  start, tile_req, tile_col, tile_row, map_data,
    output map_addr, x_out, y_out, sprite_id_out, begin_draw, busy, done, req_err
  );

endinterface

// File: rtl/board_renderer.sv
// Walks the 20x15 tile map, fetches each sprite id from the map RAM and
// issues one begin_draw request per tile to the 8x8 sprite drawer.
module board_renderer
  import board_renderer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  board_renderer_if.slave  bus
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              begin_draw_q, begin_draw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_err_q, req_err_d;

  logic last_tile_c;
  logic job_end_c;
  logic in_range_c;

  assign last_tile_c = (col_q == COL_W'(COLS - 1)) && (row_q == ROW_W'(ROWS - 1));
  assign job_end_c   = (mode_q == MODE_SINGLE) || last_tile_c;
  assign in_range_c  = (bus.tile_col < COL_W'(COLS)) && (bus.tile_row < ROW_W'(ROWS));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (bus.start || (bus.tile_req && in_range_c)) state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_RD_WAIT;
      ST_RD_WAIT:   state_d = ST_GO;
      ST_GO:        if (cnt_q == CNT_W'(GO_CYCLES - 1)) state_d = ST_DRAW_WAIT;
      ST_DRAW_WAIT: if (cnt_q == CNT_W'(DRAW_CYCLES - 1)) state_d = ST_ADVANCE;
      ST_ADVANCE:   state_d = job_end_c ? ST_IDLE : ST_FETCH;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; outputs are decoded from state_d so the
  // registered versions line up with the state they belong to.
  always_comb begin
    mode_d = mode_q;
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    cnt_d  = '0;
    x_d    = x_q;
    y_d    = y_q;
    id_d   = id_q;

    if ((state_q == ST_GO || state_q == ST_DRAW_WAIT) && state_d == state_q)
      cnt_d = cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d = MODE_FULL;
          col_d  = '0;
          row_d  = '0;
          addr_d = '0;
        end else if (bus.tile_req && in_range_c) begin
          mode_d = MODE_SINGLE;
          col_d  = bus.tile_col;
          row_d  = bus.tile_row;
          addr_d = tile_addr(bus.tile_col, bus.tile_row);
        end
      end
      ST_RD_WAIT: begin
        id_d = bus.map_data;
        x_d  = X_W'(col_q) << TILE_SHIFT;
        y_d  = Y_W'(row_q) << TILE_SHIFT;
      end
      ST_ADVANCE: begin
        if (!job_end_c) begin
          addr_d = addr_q + ADDR_W'(1);
          if (col_q == COL_W'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: ;
    endcase

    begin_draw_d = (state_d == ST_GO);
    done_d       = (state_d == ST_ADVANCE) && job_end_c;
    busy_d       = (state_d != ST_IDLE) && !done_d;
    req_err_d    = (state_q == ST_IDLE) && !bus.start && bus.tile_req && !in_range_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= MODE_FULL;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      id_q         <= '0;
      begin_draw_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      req_err_q    <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      id_q         <= id_d;
      begin_draw_q <= begin_draw_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      req_err_q    <= req_err_d;
    end
  end

  assign bus.map_addr      = addr_q;
  assign bus.x_out         = x_q;
  assign bus.y_out         = y_q;
  assign bus.sprite_id_out = id_q;
  assign bus.begin_draw    = begin_draw_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.req_err       = req_err_q;

endmodule
